// File: rtl/mag_compare_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial wide magnitude comparator.
package mag_compare_seq_ctrl_pkg;

  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCompare = 2'b01,
    StDone    = 2'b10
  } state_e;

endpackage

// File: rtl/mag_compare_4bit_df.sv
// Combinational 4-bit unsigned magnitude comparator, dataflow style.
module mag_compare_4bit_df (
  output logic       A_lt_B,
  output logic       A_eq_B,
  output logic       A_gt_B,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  assign A_lt_B = (A < B);
  assign A_eq_B = (A == B);
  assign A_gt_B = (A > B);

endmodule

// File: rtl/mag_compare_seq_ctrl.sv
// Wide unsigned compare by walking one 4-bit comparator slice MS nibble first,
// stopping at the first unequal nibble; start/busy/done handshake.
module mag_compare_seq_ctrl
  import mag_compare_seq_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                    clock,
  input  logic                    reset_b,
  input  logic                    start,
  input  logic [NibW*NIBBLES-1:0] A,
  input  logic [NibW*NIBBLES-1:0] B,
  output logic                    busy,
  output logic                    done,
  output logic                    A_lt_B,
  output logic                    A_eq_B,
  output logic                    A_gt_B,
  output logic [CNT_W-1:0]        nib_cnt
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned OpW  = NibW * NIBBLES;

  state_e            state_q, state_d;
  logic [OpW-1:0]    a_q, b_q;
  logic [IdxW-1:0]   idx_q;
  logic              lt_q, eq_q, gt_q;
  logic [CNT_W-1:0]  nib_cnt_q;

  logic [NibW-1:0]   nib_a, nib_b;
  logic              slice_lt, slice_eq, slice_gt;
  logic              accept;
  logic              last_nib;

  assign nib_a    = a_q[NibW*idx_q +: NibW];
  assign nib_b    = b_q[NibW*idx_q +: NibW];
  assign last_nib = (idx_q == '0);
  // DONE accepts start exactly like IDLE so back-to-back compares lose no cycle.
  assign accept   = start && (state_q != StCompare);

  mag_compare_4bit_df u_slice (
    .A_lt_B (slice_lt),
    .A_eq_B (slice_eq),
    .A_gt_B (slice_gt),
    .A      (nib_a),
    .B      (nib_b)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StCompare;
      end
      StCompare: begin
        if (!slice_eq || last_nib) state_d = StDone;
      end
      StDone: begin
        state_d = start ? StCompare : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StCompare);
    done = (state_q == StDone);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      nib_cnt_q <= '0;
    end else if (accept) begin
      a_q       <= A;
      b_q       <= B;
      idx_q     <= IdxW'(NIBBLES - 1);
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      nib_cnt_q <= '0;
    end else if (state_q == StCompare) begin
      nib_cnt_q <= nib_cnt_q + 1'b1;
      if (slice_lt) begin
        lt_q <= 1'b1;
      end else if (slice_gt) begin
        gt_q <= 1'b1;
      end else if (last_nib) begin
        eq_q <= 1'b1;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign A_lt_B  = lt_q;
  assign A_eq_B  = eq_q;
  assign A_gt_B  = gt_q;
  assign nib_cnt = nib_cnt_q;

endmodule

// File: tb/tb_mag_compare_seq_ctrl.sv
// Scoreboard bench: the driver queues hand-computed results, the monitor checks each done pulse.
module tb_mag_compare_seq_ctrl;

  typedef struct {
    logic       lt;
    logic       eq;
    logic       gt;
    logic [4:0] cnt;
    int         cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_b;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done, A_lt_B, A_eq_B, A_gt_B;
  logic [4:0]  nib_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  mag_compare_seq_ctrl #(.NIBBLES(4), .CNT_W(5)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .A_lt_B  (A_lt_B),
    .A_eq_B  (A_eq_B),
    .A_gt_B  (A_gt_B),
    .nib_cnt (nib_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: flags must be clear while busy; each done pulse is matched to the queue head.
  always @(negedge clock) begin
    if (reset_b) begin
      if (busy) check("flags_while_busy", {29'd0, A_lt_B, A_eq_B, A_gt_B}, 32'd0);
      if (done) begin
        check("busy_in_done", {31'd0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("flags", {29'd0, A_lt_B, A_eq_B, A_gt_B}, {29'd0, e.lt, e.eq, e.gt});
          check("nib_cnt", {27'd0, nib_cnt}, {27'd0, e.cnt});
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Drive start for one edge and queue the expected result; returns #1 after the start edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                          input logic lt, input logic eq, input logic gt, input int k);
    exp_t e;
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clock);
    #1;
    e.lt  = lt;
    e.eq  = eq;
    e.gt  = gt;
    e.cnt = 5'(k);
    e.cyc = cyc + k;
    sb_q.push_back(e);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) return;
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    reset_b = 1'b0;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    #12;
    check("reset_outputs", {25'd0, busy, done, A_lt_B, A_eq_B, A_gt_B, nib_cnt}, 32'd0);
    @(negedge clock);
    reset_b = 1'b1;
    @(negedge clock);

    // MS nibble decides immediately.
    do_start(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 1);
    wait_done("t1");
    @(negedge clock);
    check("flags_hold_after_done", {29'd0, A_lt_B, A_eq_B, A_gt_B}, 32'd1);

    // Decided on the LS nibble; busy over cycles 1-4.
    do_start(16'h1234, 16'h1235, 1'b1, 1'b0, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("busy_window", {30'd0, busy, done}, 32'd2);
    end
    wait_done("t2");
    @(negedge clock);

    // Equal operands, then back-to-back start in the DONE cycle.
    do_start(16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 4);
    wait_done("t3a");
    do_start(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4);
    wait_done("t3b");
    @(negedge clock);

    // Start while busy is ignored.
    do_start(16'h1F00, 16'h1E00, 1'b0, 1'b0, 1'b1, 2);
    @(negedge clock);
    start = 1'b1;
    A     = 16'h0000;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("t4");
    @(negedge clock);

    // Inputs change after acceptance; latched values are used.
    do_start(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 4);
    A = 16'hFFFF;
    B = 16'h0000;
    wait_done("t5");
    @(negedge clock);

    // Reset mid-compare aborts without a done pulse.
    do_start(16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b0, 4);
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b0;
    #1;
    check("abort_outputs", {25'd0, busy, done, A_lt_B, A_eq_B, A_gt_B, nib_cnt}, 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clock);
    check("abort_no_done", {31'd0, done}, 32'd0);
    reset_b = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("post_abort_idle", {30'd0, busy, done}, 32'd0);
    end
    do_start(16'h00FF, 16'h00FE, 1'b0, 1'b0, 1'b1, 4);
    wait_done("t6");
    @(negedge clock);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mag_compare_seq_ctrl.md
Name: mag_compare_seq_ctrl

Overview:
Sequencing controller that compares two wide unsigned operands by driving one 4-bit magnitude comparator slice over several clock cycles, most-significant nibble first. It stops early at the first unequal nibble. It reuses the team's combinational 4-bit comparator rather than building a wide comparator. Results are delivered with a start/busy/done handshake to any datapath needing wide magnitude compares.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 1..16
CNT_W, 5, width of nib_cnt; must hold the value NIBBLES

Ports:
clock  input  1  rising-edge clock
reset_b  input  1  asynchronous active-low reset
start  input  1  request a compare; sampled only when busy=0
A  input  4*NIBBLES  operand A, unsigned; captured on accepted start
B  input  4*NIBBLES  operand B, unsigned; captured on accepted start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse; result flags are valid in this cycle and afterwards
A_lt_B  output  1  registered result flag
A_eq_B  output  1  registered result flag
A_gt_B  output  1  registered result flag
nib_cnt  output  CNT_W  number of nibbles examined by the last compare

Behaviour:
- Reset (reset_b=0, async): state=IDLE. busy, done, A_lt_B, A_eq_B, A_gt_B and nib_cnt all 0. Operand registers and index are cleared. Reset during COMPARE aborts the operation with no done pulse.
- States: IDLE, COMPARE, DONE.
- IDLE: if start=1 at a rising edge, then on that edge:
  - latch A and B into internal registers;
  - idx <= NIBBLES-1;
  - clear all flags and nib_cnt to 0;
  - busy <= 1; go to COMPARE.
- COMPARE, one nibble per cycle:
  - The slice sees nibble idx of the latched A and B (bits 4*idx+3 .. 4*idx).
  - nib_cnt increments on each COMPARE edge.
  - Slice lt or gt → register that flag, go to DONE.
  - Slice eq and idx=0 → register A_eq_B=1, go to DONE.
  - Otherwise → idx <= idx-1, stay in COMPARE.
- DONE: lasts one cycle with done=1 and busy=0, then goes to IDLE. start=1 during DONE is accepted exactly as in IDLE, so back-to-back operation loses no cycle.
- Latency: let k be the number of nibbles examined (1..NIBBLES). done is high in cycle k+1 after the start edge (cycle 1 = first COMPARE cycle). Equal operands give k=NIBBLES.
- Exactly one result flag is high from done until the next accepted start. All flags are 0 while busy=1.
- start while busy=1 is ignored. The A/B inputs may change freely after acceptance.
- NIBBLES=1 degenerates to a single COMPARE cycle.

Decomposition:
- Shared include/package: state encodings (IDLE=2'b00, COMPARE=2'b01, DONE=2'b10) and the nibble width constant (4).
- One sub-module, instantiated once: the existing 4-bit dataflow magnitude comparator mag_compare_4bit_df, port order (A_lt_B, A_eq_B, A_gt_B, A, B).
- Everything else (FSM, operand registers, index counter, nibble mux, result registers) lives in mag_compare_seq_ctrl.

Test Plan (NIBBLES=4):
- A=16'h8000, B=16'h0001, start for 1 cycle → done in cycle 2; A_gt_B=1, nib_cnt=1.
- A=16'h1234, B=16'h1235 → done in cycle 5; A_lt_B=1, nib_cnt=4; busy high in cycles 1-4.
- A=B=16'hABCD → done in cycle 5; A_eq_B=1, nib_cnt=4. Then A=B=16'h0000 with start asserted in the DONE cycle → second done 5 cycles later, A_eq_B=1.
- A=16'h1F00, B=16'h1E00; start re-pulsed in cycle 1 with A=16'h0000 → second start ignored; done in cycle 3, A_gt_B=1, nib_cnt=2.
- A=16'h0001, B=16'h0002; A and B change to 16'hFFFF/16'h0000 in cycle 1 → result uses the latched values: A_lt_B=1, nib_cnt=4.
- reset_b pulled low mid-compare (cycle 2 of an equal-operand compare) → all outputs 0 immediately and no done pulse. A new start after release completes normally.
